// File: rtl/count_down.sv
// Programmable down-counter with one-shot / auto-reload modes, pause and stop.
module count_down #(
    parameter int unsigned WIDTH        = 7,
    parameter int unsigned DEFAULT_LOAD = 99
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_start,
    input  logic             i_mode,
    input  logic             i_pause,
    input  logic             i_stop,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_busy,
    output logic             o_done,
    output logic [1:0]       o_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] reload_q, reload_n;
    logic             mode_q, mode_n;
    logic             done_q, done_n;
    logic             busy_q, busy_n;
    logic [WIDTH-1:0] start_val;

    // Next-state, next-count and registered-output decode.
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        reload_n  = reload_q;
        mode_n    = mode_q;
        done_n    = 1'b0;
        // A simultaneous load feeds the start directly.
        start_val = i_load ? i_load_val : reload_q;

        case (state_q)
            IDLE, DONE: begin
                if (i_load) begin
                    reload_n = i_load_val;
                    cnt_n    = i_load_val;
                    if (state_q == DONE) begin
                        state_n = IDLE;
                    end
                end
                if (i_start) begin
                    mode_n = i_mode;
                    cnt_n  = start_val;
                    if (start_val == '0) begin
                        done_n  = 1'b1;
                        state_n = i_mode ? RUN : DONE;
                    end else begin
                        state_n = RUN;
                    end
                end
            end
            RUN, PAUSE: begin
                if (i_stop) begin
                    state_n = IDLE;
                end else if (i_pause) begin
                    state_n = PAUSE;
                end else if (cnt_q > WIDTH'(1)) begin
                    cnt_n   = cnt_q - WIDTH'(1);
                    state_n = RUN;
                end else if (cnt_q == WIDTH'(1)) begin
                    cnt_n   = '0;
                    done_n  = 1'b1;
                    state_n = RUN;
                end else if (mode_q) begin
                    // Terminal cycle of auto-reload: a zero reload pulses every cycle.
                    cnt_n   = reload_q;
                    done_n  = (reload_q == '0);
                    state_n = RUN;
                end else begin
                    state_n = DONE;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n == RUN) || (state_n == PAUSE);
    end

    // State, counter, reload register and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= WIDTH'(DEFAULT_LOAD);
            mode_q   <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            reload_q <= reload_n;
            mode_q   <= mode_n;
            done_q   <= done_n;
            busy_q   <= busy_n;
        end
    end

    assign o_cnt   = cnt_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;
    assign o_state = state_q;

endmodule
